instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  - Instruction-fetch stage plus IF/ID register for the RV64 datapath. Drives top_control directly upstream.
//  - Holds PC and a word-addressed instruction memory; registers the fetched instruction.
//  - Presents decoded fields Opcode/Funct/rd/rs1/rs2 and a sign-extended immediate to control and register file.
//  - Supports stall, branch redirect with flush, and a program-load write port.
// PARAMETERS
//  PC_WIDTH    64      width of PC, branch target and immediate
//  IMEM_DEPTH  64      instruction memory depth in 32-bit words (power of 2)
//  RESET_PC    0       PC value loaded on reset
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           synchronous, active-high reset
//  stall          in   1           hold PC and IF/ID contents
//  branch_taken   in   1           redirect: Branch & Zero from execute
//  branch_target  in   PC_WIDTH    redirect address
//  imem_we        in   1           program-load write enable
//  imem_waddr     in   log2(IMEM_DEPTH)  word address for load
//  imem_wdata     in   32          instruction word to load
//  pc_out         out  PC_WIDTH    PC of the instruction held in IF/ID
//  instr_out      out  32          registered instruction
//  valid_out      out  1           IF/ID holds a real (non-bubble) instruction
//  Opcode         out  7           instr_out[6:0]
//  Funct          out  4           {instr_out[30], instr_out[14:12]}
//  rd / rs1 / rs2 out  5 each      instr_out[11:7] / [19:15] / [24:20]
//  imm            out  PC_WIDTH    sign-extended immediate
// BEHAVIOUR
//  - Reset:
//      pc <= RESET_PC; pc_out <= 0; instr_out <= 32'h00000013 (NOP); valid_out <= 0.
//      imem contents are not cleared. Reset mid-operation discards any in-flight instruction.
//  - Priority each edge: reset > branch_taken > stall > normal.
//  - Normal:
//      IF/ID <= {imem[pc[k+1:2]], pc}; valid_out <= 1; pc <= pc + 4.
//      k = log2(IMEM_DEPTH); index wraps modulo IMEM_DEPTH.
//      pc itself is not wrapped; it rolls over at 2^PC_WIDTH.
//  - branch_taken:
//      pc <= {branch_target[PC_WIDTH-1:2], 2'b00} (misaligned low bits dropped).
//      IF/ID <= NOP with valid_out <= 0, pc_out <= 0 (one-cycle bubble). stall is ignored.
//  - stall (no branch): pc, instr_out, pc_out, valid_out all hold.
//  - Latency: 1 cycle from pc to IF/ID outputs. Decoded fields and imm are combinational from instr_out.
//  - First valid instruction: valid_out = 1 on the first edge after reset deasserts.
//  - imem:
//      Write on clk edge when imem_we, independent of stall/branch. Not blocked by reset.
//      Read is combinational from the array; a same-cycle write to the address being fetched is captured old-data.
//  - imm by Opcode, all sign-extended from instr[31]:
//      0000011/0010011/1100111 I  : instr[31:20]
//      0100011               S    : {instr[31:25], instr[11:7]}
//      1100011               SB   : {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
//      0110111/0010111       U    : {instr[31:12], 12'b0}
//      1101111               UJ   : {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
//      other (incl. 0110011)      : 0
// CONFIGURATION
//  IFETCH_PERF_CNT_EN
//  - Defined: adds outputs cyc_cnt[31:0], stall_cnt[31:0], flush_cnt[31:0].
//      cyc_cnt increments every non-reset cycle; stall_cnt on stall && !branch_taken; flush_cnt on branch_taken.
//      All counters clear on reset and wrap at 2^32.
//  - Undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  - Reset:
//      Load imem[0..3] = 00A00093, 00B00113, 002081B3, 40208233; hold reset 2 cycles.
//      -> valid_out = 0, instr_out = 00000013; first edge after release: instr_out = 00A00093, pc_out = 0, imm = 10.
//  - R-type decode:
//      Fetch 002081B3 -> Opcode = 0110011, Funct = 0000, rd = 3, rs1 = 1, rs2 = 2, imm = 0.
//      Next fetch 40208233 -> Funct = 1000.
//  - Stall:
//      Assert stall 3 cycles while instr_out = 00B00113, pc_out = 4.
//      -> outputs unchanged for 3 cycles; pc_out = 8 on the first edge after release.
//  - Branch:
//      branch_taken = 1, branch_target = 0x0E (with stall = 1 simultaneously).
//      -> next edge: valid_out = 0, instr_out = 00000013; following edge: pc_out = 0x0C.
//  - Decode/wrap:
//      imem[4] = FE000EE3 -> SB imm = -4 (all ones except low 2 bits 00).
//      Run PC to 4*IMEM_DEPTH -> fetches imem[0] again.
//  - IFETCH_PERF_CNT_EN:
//      10 cycles after reset with 3 stall cycles and 1 branch -> cyc_cnt = 10, stall_cnt = 3, flush_cnt = 1.

Source files
------------

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: redirect/stall controls, program-load port and the IF/ID outputs
// with their decoded fields. The fetch stage is the slave; control/loader is the master.
interface instr_fetch_stage_if #(
    parameter int PC_WIDTH   = 64,
    parameter int IMEM_DEPTH = 64
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic                stall;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic                imem_we;
    logic [AW-1:0]       imem_waddr;
    logic [31:0]         imem_wdata;

    logic [PC_WIDTH-1:0] pc_out;
    logic [31:0]         instr_out;
    logic                valid_out;
    logic [6:0]          Opcode;
    logic [3:0]          Funct;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [PC_WIDTH-1:0] imm;

    modport master (
        output stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
        input  pc_out, instr_out, valid_out, Opcode, Funct, rd, rs1, rs2, imm
    );

    modport slave (
        input  stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
        output pc_out, instr_out, valid_out, Opcode, Funct, rd, rs1, rs2, imm
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// RV64 instruction fetch + IF/ID register with word-addressed imem, stall, branch flush.
// Optional IFETCH_PERF_CNT_EN adds cycle/stall/flush counters.
module instr_fetch_stage #(
    parameter int                  PC_WIDTH   = 64,
    parameter int                  IMEM_DEPTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic        clk,
    input  logic        reset,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0] cyc_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    instr_fetch_stage_if.slave bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~{{(PC_WIDTH-2){1'b0}}, 2'b11};

    logic [31:0]         imem [IMEM_DEPTH];
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] ifid_pc;
    logic [31:0]         ifid_instr;
    logic                ifid_vld;
    logic [31:0]         fetch_word;

    // Index wraps modulo the depth; pc itself keeps counting.
    assign fetch_word = imem[pc[AW+1:2]];

    // Loader port runs regardless of reset/stall/branch so a program can be
    // written while the pipeline is held in reset.
    always_ff @(posedge clk) begin
        if (bus.imem_we)
            imem[bus.imem_waddr] <= bus.imem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            ifid_pc    <= '0;
            ifid_instr <= NOP;
            ifid_vld   <= 1'b0;
        end else if (bus.branch_taken) begin
            pc         <= bus.branch_target & ALIGN_MASK;
            ifid_pc    <= '0;
            ifid_instr <= NOP;
            ifid_vld   <= 1'b0;
        end else if (!bus.stall) begin
            pc         <= pc + PC_WIDTH'(4);
            ifid_pc    <= pc;
            ifid_instr <= fetch_word;
            ifid_vld   <= 1'b1;
        end
    end

    assign bus.pc_out    = ifid_pc;
    assign bus.instr_out = ifid_instr;
    assign bus.valid_out = ifid_vld;
    assign bus.Opcode    = ifid_instr[6:0];
    assign bus.Funct     = {ifid_instr[30], ifid_instr[14:12]};
    assign bus.rd        = ifid_instr[11:7];
    assign bus.rs1       = ifid_instr[19:15];
    assign bus.rs2       = ifid_instr[24:20];

    logic [PC_WIDTH-1:0] imm_c;
    always_comb begin
        imm_c = '0;
        unique case (ifid_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                imm_c = {{(PC_WIDTH-12){ifid_instr[31]}}, ifid_instr[31:20]};
            7'b0100011:
                imm_c = {{(PC_WIDTH-12){ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
            7'b1100011:
                imm_c = {{(PC_WIDTH-13){ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                         ifid_instr[30:25], ifid_instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm_c = {{(PC_WIDTH-32){ifid_instr[31]}}, ifid_instr[31:12], 12'b0};
            7'b1101111:
                imm_c = {{(PC_WIDTH-21){ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                         ifid_instr[20], ifid_instr[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end
    assign bus.imm = imm_c;

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (bus.stall && !bus.branch_taken)
                stall_cnt <= stall_cnt + 32'd1;
            if (bus.branch_taken)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: transaction-level model plus per-cycle compare.
module tb_instr_fetch_stage;
    localparam int PCW   = 64;
    localparam int DEPTH = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_stage_if #(.PC_WIDTH(PCW), .IMEM_DEPTH(DEPTH)) bus ();

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
`endif

    instr_fetch_stage #(.PC_WIDTH(PCW), .IMEM_DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef IFETCH_PERF_CNT_EN
        .cyc_cnt   (cyc_cnt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Model state
    logic [31:0]    m_imem [DEPTH];
    logic [PCW-1:0] m_pc, m_pco;
    logic [31:0]    m_ins;
    logic           m_vld;
    int unsigned    m_cyc, m_stl, m_fls;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Immediate by arithmetic weight of each field, not by bit splicing.
    function automatic longint exp_imm(input logic [31:0] i);
        longint r;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: r = (i[31] ? -64'sd2048 : 64'sd0) + longint'(i[30:20]);
            7'h23: r = (i[31] ? -64'sd2048 : 64'sd0) + longint'(i[30:25]) * 32 + longint'(i[11:7]);
            7'h63: r = (i[31] ? -64'sd4096 : 64'sd0) + longint'(i[7]) * 2048
                       + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            7'h37, 7'h17: r = (i[31] ? -64'sd2147483648 : 64'sd0) + longint'(i[30:12]) * 4096;
            7'h6F: r = (i[31] ? -64'sd1048576 : 64'sd0) + longint'(i[19:12]) * 4096
                       + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            default: r = 0;
        endcase
        return r;
    endfunction

    // One clock edge: advance the model from the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_pc = '0; m_pco = '0; m_ins = NOP; m_vld = 0;
            m_cyc = 0; m_stl = 0; m_fls = 0;
        end else begin
            m_cyc++;
            if (bus.branch_taken) begin
                m_pc  = bus.branch_target - (bus.branch_target % 4);
                m_pco = '0; m_ins = NOP; m_vld = 0;
                m_fls++;
            end else if (bus.stall) begin
                m_stl++;
            end else begin
                m_ins = m_imem[int'((m_pc / 4) % DEPTH)];
                m_pco = m_pc; m_vld = 1;
                m_pc  = m_pc + 4;
            end
        end
        if (bus.imem_we) m_imem[int'(bus.imem_waddr)] = bus.imem_wdata;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_out",    bus.pc_out,    m_pco);
            chk("instr_out", bus.instr_out, m_ins);
            chk("valid_out", bus.valid_out, m_vld);
            chk("Opcode",    bus.Opcode,    m_ins % 128);
            chk("Funct",     bus.Funct,     m_ins[30] * 8 + m_ins[14:12]);
            chk("rd",        bus.rd,        (m_ins >> 7) % 32);
            chk("rs1",       bus.rs1,       (m_ins >> 15) % 32);
            chk("rs2",       bus.rs2,       (m_ins >> 20) % 32);
            chk("imm",       bus.imm,       exp_imm(m_ins));
`ifdef IFETCH_PERF_CNT_EN
            chk("cyc_cnt",   cyc_cnt,   m_cyc);
            chk("stall_cnt", stall_cnt, m_stl);
            chk("flush_cnt", flush_cnt, m_fls);
`endif
        end
    end

    logic [31:0] prog [4] = '{32'h00A00093, 32'h00B00113, 32'h002081B3, 32'h40208233};
    logic [31:0] tmpl [6] = '{32'h80012083, 32'h7FF0A023, 32'hFE1FF06F,
                              32'h123452B7, 32'h80000463, 32'h00000073};

    initial begin
        bit hit;
        reset = 1;
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
        bus.imem_we = 0; bus.imem_waddr = '0; bus.imem_wdata = '0;

        // Program load while held in reset.
        for (int a = 0; a < DEPTH; a++) begin
            bus.imem_we    = 1;
            bus.imem_waddr = a[5:0];
            if (a < 4)       bus.imem_wdata = prog[a];
            else if (a == 4) bus.imem_wdata = 32'hFE000EE3;
            else             bus.imem_wdata = tmpl[a % 6] ^ (32'(a) << 7);
            tick();
            chk_en = 1;
        end
        bus.imem_we = 0;
        tick(); tick();
        chk("rst valid_out", bus.valid_out, 0);
        chk("rst instr_out", bus.instr_out, NOP);

        reset = 0;
        tick();
        chk("first instr", bus.instr_out, 32'h00A00093);
        chk("first pc",    bus.pc_out,    0);
        chk("first imm",   bus.imm,       64'd10);
        chk("first valid", bus.valid_out, 1);
        tick();

        bus.stall = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall instr", bus.instr_out, 32'h00B00113);
            chk("stall pc",    bus.pc_out,    4);
        end
        bus.stall = 0;
        tick();
        chk("post-stall pc", bus.pc_out, 8);
        chk("R opcode", bus.Opcode, 7'b0110011);
        chk("R funct",  bus.Funct,  4'b0000);
        chk("R rd",     bus.rd,  3);
        chk("R rs1",    bus.rs1, 1);
        chk("R rs2",    bus.rs2, 2);
        chk("R imm",    bus.imm, 0);
        tick();
        chk("sub funct", bus.Funct, 4'b1000);

        // Branch wins over a simultaneous stall.
        bus.branch_taken = 1; bus.branch_target = 64'h0E; bus.stall = 1;
        tick();
        bus.branch_taken = 0; bus.stall = 0;
        chk("br valid", bus.valid_out, 0);
        chk("br instr", bus.instr_out, NOP);
        tick();
        chk("br target pc", bus.pc_out, 64'h0C);
        tick();
        chk("SB imm", bus.imm, 64'hFFFF_FFFF_FFFF_FFFC);

        // Run until pc reaches 4*DEPTH; imem index must wrap to 0.
        hit = 0;
        for (int c = 0; c < 80 && !hit; c++) begin
            tick();
            if (bus.pc_out == 64'(4 * DEPTH)) hit = 1;
        end
        chk("wrap reached", hit, 1);
        chk("wrap instr", bus.instr_out, 32'h00A00093);

        // Write to the word being fetched this same edge: old data captured.
        bus.imem_we = 1; bus.imem_waddr = 6'd1; bus.imem_wdata = 32'h00700393;
        tick();
        bus.imem_we = 0;
        chk("old-data read", bus.instr_out, 32'h00B00113);
        bus.branch_taken = 1; bus.branch_target = 64'h5;
        tick();
        bus.branch_taken = 0;
        tick();
        chk("misalign pc", bus.pc_out, 64'h4);
        chk("new-data read", bus.instr_out, 32'h00700393);

        // PC rollover at 2^64.
        bus.branch_taken = 1; bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus.branch_taken = 0;
        tick();
        chk("top pc", bus.pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("rollover pc", bus.pc_out, 0);
        chk("rollover instr", bus.instr_out, 32'h00A00093);

        // Reset mid-run discards the in-flight instruction.
        reset = 1;
        tick();
        chk("midrst valid", bus.valid_out, 0);
        chk("midrst instr", bus.instr_out, NOP);
        reset = 0;
        tick();
        chk("midrst restart pc", bus.pc_out, 0);

`ifdef IFETCH_PERF_CNT_EN
        reset = 1;
        tick();
        reset = 0;
        tick();
        bus.stall = 1;
        for (int c = 0; c < 3; c++) tick();
        bus.stall = 0; bus.branch_taken = 1; bus.branch_target = '0;
        tick();
        bus.branch_taken = 0;
        for (int c = 0; c < 5; c++) tick();
        chk("perf cyc",   cyc_cnt,   10);
        chk("perf stall", stall_cnt, 3);
        chk("perf flush", flush_cnt, 1);
`endif

        @(negedge clk);
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
